// File: rtl/arbitro_vc.sv
// arbitro_vc: weighted round-robin pop arbiter between the VC0 and VC1 FIFOs.
// Pops are combinational; the selector and pop_delay qualifiers are registered
// one cycle later so the VC mux can line them up with the FIFO read data.
// Optional build macro ARB_STRICT_PRIO_EN: VC0 gets strict priority and the
// credit counter is removed (WEIGHT_VC0 is ignored).
module arbitro_vc #(
    parameter int unsigned WEIGHT_VC0 = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       empty_VC0,
    input  logic       empty_VC1,
    input  logic       almost_full_D0,
    input  logic       almost_full_D1,
    output logic       pop_VC0,
    output logic       pop_VC1,
    output logic       pop_delay_VC0,
    output logic       pop_delay_VC1,
    output logic       selector,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_STALL = 2'd3
    } arb_state_t;

    arb_state_t state_q;
    arb_state_t state_d;
    logic       stall;
    logic       pop0;
    logic       pop1;

    assign stall   = almost_full_D0 | almost_full_D1;
    assign pop_VC0 = pop0;
    assign pop_VC1 = pop1;

`ifdef ARB_STRICT_PRIO_EN
    // Strict priority grant: VC1 only when VC0 has nothing to offer.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (reset_L && !stall) begin
            if (!empty_VC0) begin
                pop0 = 1'b1;
            end else if (!empty_VC1) begin
                pop1 = 1'b1;
            end
        end
    end
`else
    localparam logic [CNT_W-1:0] WEIGHT_C = CNT_W'(WEIGHT_VC0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Weighted grant: VC0 wins contention until it has spent its credits.
    always_comb begin
        pop0  = 1'b0;
        pop1  = 1'b0;
        cnt_d = cnt_q;
        if (reset_L && !stall) begin
            if (!empty_VC0 && (empty_VC1 || (cnt_q < WEIGHT_C))) begin
                pop0 = 1'b1;
            end else if (!empty_VC1) begin
                pop1 = 1'b1;
            end
        end
        // Only contended VC0 grants consume credit; any VC1 grant refills.
        if (pop0 && !empty_VC1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop1) begin
            cnt_d = '0;
        end
    end

    // Credit counter register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Debug state next value, stall taking precedence over any grant.
    always_comb begin
        state_d = ST_IDLE;
        if (stall) begin
            state_d = ST_STALL;
        end else if (pop0) begin
            state_d = ST_GNT0;
        end else if (pop1) begin
            state_d = ST_GNT1;
        end
    end

    // State, data-valid qualifiers and mux selector registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= ST_IDLE;
            pop_delay_VC0 <= 1'b0;
            pop_delay_VC1 <= 1'b0;
            selector      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pop_delay_VC0 <= pop0;
            pop_delay_VC1 <= pop1;
            if (pop1) begin
                selector <= 1'b1;
            end else if (pop0) begin
                selector <= 1'b0;
            end
        end
    end

    assign arb_state = state_q;

endmodule

// File: tb/tb_arbitro_vc.sv
// Directed bench for arbitro_vc (WEIGHT_VC0 = 2). Inputs change on the falling
// edge; all outputs are sampled 1 time unit later, so combinational pops show
// this cycle's decision and registered outputs show the previous cycle's.
module tb_arbitro_vc;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       empty_VC0;
    logic       empty_VC1;
    logic       almost_full_D0;
    logic       almost_full_D1;
    logic       pop_VC0;
    logic       pop_VC1;
    logic       pop_delay_VC0;
    logic       pop_delay_VC1;
    logic       selector;
    logic [1:0] arb_state;

    int checks = 0;
    int errors = 0;

    arbitro_vc #(.WEIGHT_VC0(2), .CNT_W(4)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .empty_VC0      (empty_VC0),
        .empty_VC1      (empty_VC1),
        .almost_full_D0 (almost_full_D0),
        .almost_full_D1 (almost_full_D1),
        .pop_VC0        (pop_VC0),
        .pop_VC1        (pop_VC1),
        .pop_delay_VC0  (pop_delay_VC0),
        .pop_delay_VC1  (pop_delay_VC1),
        .selector       (selector),
        .arb_state      (arb_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r;
        logic e0;
        logic e1;
        logic af0;
        logic af1;
    } in_t;

    typedef struct packed {
        logic       p0;
        logic       p1;
        logic       pd0;
        logic       pd1;
        logic       sel;
        logic [1:0] st;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input out_t exp);
        chk({tag, " pop_VC0"},       {1'b0, pop_VC0},       {1'b0, exp.p0});
        chk({tag, " pop_VC1"},       {1'b0, pop_VC1},       {1'b0, exp.p1});
        chk({tag, " pop_delay_VC0"}, {1'b0, pop_delay_VC0}, {1'b0, exp.pd0});
        chk({tag, " pop_delay_VC1"}, {1'b0, pop_delay_VC1}, {1'b0, exp.pd1});
        chk({tag, " selector"},      {1'b0, selector},      {1'b0, exp.sel});
        chk({tag, " arb_state"},     arb_state,             exp.st);
    endtask

    task automatic drive(input in_t v);
        reset_L        = v.r;
        empty_VC0      = v.e0;
        empty_VC1      = v.e1;
        almost_full_D0 = v.af0;
        almost_full_D1 = v.af1;
    endtask

`ifndef ARB_STRICT_PRIO_EN
    localparam int unsigned NV = 28;
    vec_t vecs [NV];
`endif

    initial begin
        drive(5'b0_0_0_0_0);

`ifndef ARB_STRICT_PRIO_EN
        // inputs {r,e0,e1,af0,af1}  expected {p0,p1,pd0,pd1,sel,st}
        vecs[0]  = '{5'b0_0_0_0_0, 7'b0_0_0_0_0_00}; // held in reset
        vecs[1]  = '{5'b1_0_1_0_0, 7'b1_0_0_0_0_00}; // release: pop same cycle
        vecs[2]  = '{5'b1_0_1_0_0, 7'b1_0_1_0_0_01}; // VC0 only
        vecs[3]  = '{5'b1_0_1_0_0, 7'b1_0_1_0_0_01};
        vecs[4]  = '{5'b1_0_1_0_0, 7'b1_0_1_0_0_01};
        vecs[5]  = '{5'b1_0_1_0_0, 7'b1_0_1_0_0_01};
        vecs[6]  = '{5'b1_0_0_0_0, 7'b1_0_1_0_0_01}; // contended, cnt 0
        vecs[7]  = '{5'b1_0_0_0_0, 7'b1_0_1_0_0_01}; // cnt 1
        vecs[8]  = '{5'b1_0_0_0_0, 7'b0_1_1_0_0_01}; // cnt 2 -> VC1
        vecs[9]  = '{5'b1_0_0_0_0, 7'b1_0_0_1_1_10};
        vecs[10] = '{5'b1_0_0_0_0, 7'b1_0_1_0_0_01};
        vecs[11] = '{5'b1_0_0_0_0, 7'b0_1_1_0_0_01};
        vecs[12] = '{5'b1_0_0_0_0, 7'b1_0_0_1_1_10}; // one VC0 grant, cnt -> 1
        vecs[13] = '{5'b1_0_0_0_1, 7'b0_0_1_0_0_01}; // stall on D1
        vecs[14] = '{5'b1_0_0_0_1, 7'b0_0_0_0_0_11};
        vecs[15] = '{5'b1_0_0_0_1, 7'b0_0_0_0_0_11};
        vecs[16] = '{5'b1_0_0_0_0, 7'b1_0_0_0_0_11}; // resume with held cnt 1
        vecs[17] = '{5'b1_0_0_0_0, 7'b0_1_1_0_0_01};
        vecs[18] = '{5'b1_0_0_0_0, 7'b1_0_0_1_1_10}; // cnt -> 1
        vecs[19] = '{5'b1_1_0_0_0, 7'b0_1_1_0_0_01}; // VC0 drains mid-burst
        vecs[20] = '{5'b1_0_0_0_0, 7'b1_0_0_1_1_10}; // cnt was cleared
        vecs[21] = '{5'b1_1_1_0_0, 7'b0_0_1_0_0_01}; // both empty
        vecs[22] = '{5'b1_1_1_0_0, 7'b0_0_0_0_0_00};
        vecs[23] = '{5'b1_0_0_1_0, 7'b0_0_0_0_0_00}; // stall on D0
        vecs[24] = '{5'b1_0_0_0_0, 7'b1_0_0_0_0_11}; // cnt 1 held through stall
        vecs[25] = '{5'b1_0_0_0_0, 7'b0_1_1_0_0_01};
        vecs[26] = '{5'b1_1_1_0_0, 7'b0_0_0_1_1_10};
        vecs[27] = '{5'b1_1_0_0_0, 7'b0_1_0_0_1_00}; // VC1 only, selector held

        for (int k = 0; k < int'(NV); k++) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            chk_all($sformatf("step%0d", k), vecs[k].o);
        end

        // Reset dropped between edges while selector/pop_delay_VC1 are high.
        @(negedge clk);
        drive(5'b1_1_0_0_0);
        #1;
        chk("pre-rst1 selector", {1'b0, selector}, 2'b01);
        #2;
        reset_L = 1'b0;
        #1;
        chk_all("rst1", 7'b0_0_0_0_0_00);

        // Restart, build cnt = 1 with pop_delay_VC0 high, then reset again.
        @(negedge clk);
        drive(5'b1_0_0_0_0);
        #1;
        chk_all("rel1", 7'b1_0_0_0_0_00);
        @(negedge clk);
        #1;
        chk_all("pre-rst2", 7'b1_0_1_0_0_01);
        #2;
        reset_L = 1'b0;
        #1;
        chk_all("rst2", 7'b0_0_0_0_0_00);

        // Counter must restart at 0: VC0, VC0, VC1.
        @(negedge clk);
        drive(5'b1_0_0_0_0);
        #1;
        chk_all("rel2 g0", 7'b1_0_0_0_0_00);
        @(negedge clk);
        #1;
        chk_all("rel2 g1", 7'b1_0_1_0_0_01);
        @(negedge clk);
        #1;
        chk_all("rel2 g2", 7'b0_1_1_0_0_01);
        @(negedge clk);
        #1;
        chk_all("rel2 g3", 7'b1_0_0_1_1_10);
`else
        // Strict priority: contended traffic always goes to VC0.
        @(negedge clk);
        #1;
        chk_all("strict rst", 7'b0_0_0_0_0_00);
        @(negedge clk);
        drive(5'b1_0_0_0_0);
        #1;
        chk_all("strict c0", 7'b1_0_0_0_0_00);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk_all($sformatf("strict c%0d", k), 7'b1_0_1_0_0_01);
        end
        @(negedge clk);
        drive(5'b1_1_0_0_0);
        #1;
        chk_all("strict vc1", 7'b0_1_1_0_0_01);
        @(negedge clk);
        drive(5'b1_0_0_0_1);
        #1;
        chk_all("strict stall", 7'b0_0_0_1_1_10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_vc.md
Name: arbitro_vc

Overview:
Weighted round-robin arbiter between the VC0 and VC1 input FIFOs. It sits directly upstream of the VC mux.
- Generates same-cycle pop requests to the FIFOs.
- Produces the registered selector and pop_delay_VC0 / pop_delay_VC1 qualifiers that the mux uses to steer the FIFO read data, which arrives one cycle after the pop.
- Stalls all traffic while either destination FIFO signals almost-full.

Parameters:
WEIGHT_VC0, 2, maximum consecutive contended VC0 grants before VC1 is granted once; legal range 1..15.
CNT_W, 4, width of the internal VC0 credit counter; must satisfy 2^CNT_W > WEIGHT_VC0.

Ports:
clk  input  1  single clock, all state on rising edge
reset_L  input  1  reset, asynchronous, active-low
empty_VC0  input  1  VC0 FIFO empty
empty_VC1  input  1  VC1 FIFO empty
almost_full_D0  input  1  destination 0 FIFO almost full (back-pressure)
almost_full_D1  input  1  destination 1 FIFO almost full (back-pressure)
pop_VC0  output  1  combinational pop to VC0 FIFO
pop_VC1  output  1  combinational pop to VC1 FIFO
pop_delay_VC0  output  1  registered pop_VC0, data-valid qualifier for mux VC0 data
pop_delay_VC1  output  1  registered pop_VC1, data-valid qualifier for mux VC1 data
selector  output  1  registered mux select: 0 = VC0, 1 = VC1
arb_state  output  2  registered debug state: 0 IDLE, 1 GNT0, 2 GNT1, 3 STALL

Behaviour:
- Reset (reset_L=0, asynchronous):
  - Clears pop_delay_VC0, pop_delay_VC1, selector and the credit counter to 0; sets arb_state to IDLE.
  - Forces pop_VC0 and pop_VC1 to 0 combinationally while reset_L=0.
- stall = almost_full_D0 | almost_full_D1. While stall=1, both pops are 0.
- Grant rules when not stalled:
  - Only VC0 non-empty: pop_VC0=1.
  - Only VC1 non-empty: pop_VC1=1.
  - Both non-empty (contended): pop_VC0=1 if cnt < WEIGHT_VC0, else pop_VC1=1.
  - Both empty: no pop.
- pop_VC0 and pop_VC1 are never both 1. A pop is never issued to an empty FIFO.
- Credit counter cnt:
  - Increments on a VC0 grant while empty_VC1=0.
  - Clears to 0 on any VC1 grant.
  - Holds on uncontended VC0 grants, idle cycles and stall cycles.
  - Never exceeds WEIGHT_VC0.
- Latency:
  - pop_delay_VCx equals pop_VCx delayed by exactly 1 cycle.
  - selector <= 1 on a cycle with pop_VC1, <= 0 on a cycle with pop_VC0, otherwise holds.
- arb_state next value, in priority order: STALL if stall; else GNT0 if pop_VC0; else GNT1 if pop_VC1; else IDLE.
- Leaving STALL: arbitration resumes with the held counter, so no grant is lost or duplicated.
- Empty changing mid-burst: the decision is re-evaluated every cycle from the current empty flags; there is no grant lock.
- Reset mid-burst: outputs clear immediately without waiting for a clock edge; the counter restarts at 0.

Optional Feature:
ARB_STRICT_PRIO_EN
- Defined: VC0 has strict priority. VC1 is popped only when empty_VC0=1. The credit counter is removed and WEIGHT_VC0 is ignored. All other timing is identical.
- Undefined: weighted round-robin as specified above.

Test Plan:
1. reset_L=0 with empty_VC0=empty_VC1=0 -> pop_VC0=pop_VC1=0, pop_delay_VC0/VC1=0, selector=0, arb_state=0; release reset -> pop_VC0=1 in the same cycle.
2. WEIGHT_VC0=2, empty_VC0=0, empty_VC1=1, no stall for 5 cycles -> pop_VC0=1 on all 5 cycles; pop_delay_VC0=1 from the 2nd cycle onward; selector=0; arb_state=1.
3. WEIGHT_VC0=2, both non-empty for 6 cycles -> grant sequence VC0,VC0,VC1,VC0,VC0,VC1; selector one cycle later reads 0,0,1,0,0,1.
4. Both non-empty; after one VC0 grant assert almost_full_D1=1 for 3 cycles -> pops 0 and arb_state=3 for those cycles; after release grants continue VC0,VC1 (counter was held at 1).
5. Both non-empty with cnt=1, then empty_VC0 rises -> pop_VC1=1 next cycle, cnt=0, selector=1 one cycle after the VC1 pop; with ARB_STRICT_PRIO_EN defined and both non-empty -> only pop_VC0 asserted for 8 cycles.
6. Drop reset_L mid-burst between clock edges -> pops, pop_delay_VC0, pop_delay_VC1 and selector go to 0 immediately; after release the weighted sequence restarts from cnt=0.
